// File: rtl/offchip_dmem_if.sv
// offchip_dmem_if: request/response bundle between a requester and offchip_dmem.
// Signals: req_i/write_i/addr_i/data_i (request), ack_o/data_o/err_o/busy_o (response).
interface offchip_dmem_if;
  logic        req_i;
  logic        write_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        ack_o;
  logic [31:0] data_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output req_i, write_i, addr_i, data_i,
    input  ack_o, data_o, err_o, busy_o
  );

  modport slave (
    input  req_i, write_i, addr_i, data_i,
    output ack_o, data_o, err_o, busy_o
  );
endinterface

// File: rtl/offchip_dmem.sv
// offchip_dmem: one-word-per-request data memory with a fixed access latency.
// Ports: clk_i, rst_i (sync, active high), bus (offchip_dmem_if.slave).
// Params: DEPTH (words, power of two), LATENCY (1..255 cycles to ack).
// Option: define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range accesses.
module offchip_dmem #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic           clk_i,
  input  logic           rst_i,
  offchip_dmem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [7:0]    cnt;
  logic          wr_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  logic          in_err;
  logic          commit;
  logic          sel_wr;
  logic          sel_err;
  logic [AW-1:0] sel_idx;
  logic [31:0]   sel_data;

`ifdef DMEM_ERR_CHECK_EN
  assign in_err = (bus.addr_i[1:0] != 2'b00) ||
                  (bus.addr_i >= 32'(DEPTH * 4));
`else
  // Index wraps modulo DEPTH; the remaining address bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};
  assign in_err = 1'b0;
`endif

  // The edge entering RESP commits the access. With LATENCY=1 that is
  // the acceptance edge itself, so the live inputs are used there.
  always_comb begin
    sel_wr   = wr_q;
    sel_err  = err_q;
    sel_idx  = idx_q;
    sel_data = wdata_q;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        sel_wr   = bus.write_i;
        sel_err  = in_err;
        sel_idx  = bus.addr_i[AW+1:2];
        sel_data = bus.data_i;
        commit   = bus.req_i && (LATENCY == 1);
      end
      WAIT: commit = (cnt == 8'd0);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            wr_q    <= bus.write_i;
            err_q   <= in_err;
            idx_q   <= bus.addr_i[AW+1:2];
            wdata_q <= bus.data_i;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= 8'(LATENCY - 2);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 8'd0) state <= RESP;
          else             cnt   <= cnt - 8'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit && !sel_wr)
        rdata_q <= sel_err ? 32'd0 : mem[sel_idx];
    end
  end

  // Storage is never reset; an aborted access never reaches commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && sel_wr && !sel_err)
      mem[sel_idx] <= sel_data;
  end

  assign bus.ack_o  = (state == RESP);
  assign bus.err_o  = (state == RESP) && err_q;
  assign bus.busy_o = (state != IDLE);
  assign bus.data_o = rdata_q;
endmodule
